// File: rtl/sa_result_collector4x4.sv
// Deskews skewed systolic-array column sums into aligned rows (issue to out_valid: BASE_LAT+3 edges).
// First-word-fall-through row FIFO toward valid/ready; in_ready withholds credit once buffered plus in-flight rows reach DEPTH.
module sa_result_collector4x4 #(
  parameter int PSW      = 18,
  parameter int BASE_LAT = 4,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     L,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PSW-1:0]           pso0,
  input  logic [PSW-1:0]           pso1,
  input  logic [PSW-1:0]           pso2,
  input  logic [PSW-1:0]           pso3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PSW-1:0]           res0,
  output logic [PSW-1:0]           res1,
  output logic [PSW-1:0]           res2,
  output logic [PSW-1:0]           res3,
  output logic [7:0]               row_idx,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int PL = BASE_LAT + 3;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
  localparam logic [OW:0]   DEPTH_W = (OW+1)'(DEPTH);

  typedef struct packed {
    logic [PSW-1:0] c0;
    logic [PSW-1:0] c1;
    logic [PSW-1:0] c2;
    logic [PSW-1:0] c3;
  } row_t;

  logic [PL-1:0]  vpipe;
  logic [PSW-1:0] s0a, s0b, s0c, s1a, s1b, s2a;
  row_t           mem [DEPTH];
  row_t           wr_row, head;
  logic [OW-1:0]  wptr, rptr, inflight;
  logic [OW:0]    credit_used;
  logic [7:0]     ridx;
  logic           issue, wr_en, pop, full;

  assign occupancy   = wptr - rptr;
  assign out_valid   = (occupancy != '0);
  assign full        = (occupancy == DEPTH_O);
  assign credit_used = {1'b0, occupancy} + {1'b0, inflight};
  assign in_ready    = !L && (credit_used < DEPTH_W);
  assign issue       = in_valid && in_ready;
  assign wr_en       = vpipe[PL-1];
  assign pop         = out_valid && out_ready;

  // Column j is already j cycles late, so it needs 3-j registers to line up with column 3.
  assign wr_row = '{c0: s0c, c1: s1b, c2: s2a, c3: pso3};

  always_ff @(posedge clk) begin
    if (!rst) begin
      vpipe <= '0;
      s0a   <= '0;
      s0b   <= '0;
      s0c   <= '0;
      s1a   <= '0;
      s1b   <= '0;
      s2a   <= '0;
    end else begin
      vpipe <= {vpipe[PL-2:0], issue};
      s0a   <= pso0;
      s0b   <= s0a;
      s0c   <= s0b;
      s1a   <= pso1;
      s1b   <= s1a;
      s2a   <= pso2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= '0;
      ridx     <= '0;
    end else begin
      if (wr_en) wptr <= wptr + OW'(1);
      if (pop) begin
        rptr <= rptr + OW'(1);
        ridx <= ridx + 8'd1;
      end
      if (issue && !wr_en)
        inflight <= inflight + OW'(1);
      else if (!issue && wr_en)
        inflight <= inflight - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wptr[AW-1:0]] <= wr_row;
  end

  assign head    = mem[rptr[AW-1:0]];
  assign res0    = out_valid ? head.c0 : '0;
  assign res1    = out_valid ? head.c1 : '0;
  assign res2    = out_valid ? head.c2 : '0;
  assign res3    = out_valid ? head.c3 : '0;
  assign row_idx = ridx;

  // Credit accounting guarantees a free slot for every row reaching the pipe tail.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) wr_en |-> !full);

endmodule

// File: tb/tb_sa_result_collector4x4.sv
// Randomized and directed bench for sa_result_collector4x4 against a queue-based row model.
module tb_sa_result_collector4x4;
  localparam int PSW   = 18;
  localparam int DEPTH = 4;
  localparam int LAT   = 7;

  typedef logic [PSW-1:0] ps_t;
  typedef struct packed { ps_t c0; ps_t c1; ps_t c2; ps_t c3; } row_t;

  logic       clk = 1'b0;
  logic       rst, L, in_valid, in_ready, out_valid, out_ready;
  ps_t        pso0, pso1, pso2, pso3, res0, res1, res2, res3;
  logic [7:0] row_idx;
  logic [2:0] occupancy;

  sa_result_collector4x4 #(.PSW(PSW), .BASE_LAT(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .L(L), .in_valid(in_valid), .in_ready(in_ready),
    .pso0(pso0), .pso1(pso1), .pso2(pso2), .pso3(pso3),
    .out_valid(out_valid), .out_ready(out_ready),
    .res0(res0), .res1(res1), .res2(res2), .res3(res3),
    .row_idx(row_idx), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  int   eridx = 0;
  bit   armed = 1'b0;
  ps_t  h0 [8192];
  ps_t  h1 [8192];
  ps_t  h2 [8192];
  ps_t  h3 [8192];
  row_t fq [$];
  int   pq [$];

  localparam ps_t PMIN = 18'h20000;
  localparam ps_t PMAX = 18'h1FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic ps_t rnd();
    return ps_t'($urandom);
  endfunction

  // One clock: drive, check settled outputs against the model, advance the model across the edge.
  task automatic cyc(input logic rv, input logic lv, input logic iv, input logic orv,
                     input ps_t a, input ps_t b, input ps_t c, input ps_t d);
    logic er;
    int   e;
    rst = rv; L = lv; in_valid = iv; out_ready = orv;
    pso0 = a; pso1 = b; pso2 = c; pso3 = d;
    #1;
    er = !lv && ((fq.size() + pq.size()) < DEPTH);
    if (armed) begin
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("out_valid", 64'(out_valid), 64'(fq.size() != 0));
      chk("occupancy", 64'(occupancy), 64'(fq.size()));
      if (fq.size() != 0) begin
        chk("res0", 64'(res0), 64'(fq[0].c0));
        chk("res1", 64'(res1), 64'(fq[0].c1));
        chk("res2", 64'(res2), 64'(fq[0].c2));
        chk("res3", 64'(res3), 64'(fq[0].c3));
        chk("row_idx", 64'(row_idx), 64'(eridx));
      end else begin
        chk("res_empty", 64'({res0, res1, res2, res3}), 64'(0));
      end
    end
    h0[n] = a; h1[n] = b; h2[n] = c; h3[n] = d;
    if (!rv) begin
      fq.delete();
      pq.delete();
      eridx = 0;
    end else begin
      if (fq.size() != 0 && orv) begin
        void'(fq.pop_front());
        eridx = (eridx + 1) % 256;
      end
      if (pq.size() != 0 && pq[0] + LAT == n) begin
        e = pq.pop_front();
        fq.push_back({h0[e+4], h1[e+5], h2[e+6], h3[e+7]});
      end
      if (iv && er) pq.push_back(n);
    end
    @(posedge clk);
    n++;
    #1;
    if (!rv) armed = 1'b1;
  endtask

  function automatic ps_t t3v(input int t, input int j);
    int k;
    k = t - 4 - j;
    return (k >= 0 && k < 4) ? ps_t'(100 * k + j) : '0;
  endfunction

  initial begin
    rst = 1'b0; L = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pso0 = '0; pso1 = '0; pso2 = '0; pso3 = '0;

    // reset
    cyc(0, 0, 0, 0, rnd(), rnd(), rnd(), rnd());
    cyc(0, 0, 0, 0, rnd(), rnd(), rnd(), rnd());
    chk("t1_valid", 64'(out_valid), 64'(0));
    chk("t1_res", 64'({res0, res1, res2, res3}), 64'(0));
    chk("t1_row_idx", 64'(row_idx), 64'(0));
    chk("t1_occ", 64'(occupancy), 64'(0));
    chk("t1_rdy", 64'(in_ready), 64'(1));

    // single row
    cyc(1, 0, 1, 0, rnd(), rnd(), rnd(), rnd());
    for (int t = 1; t <= 7; t++)
      cyc(1, 0, 0, 0, (t == 4) ? ps_t'(10) : rnd(), (t == 5) ? ps_t'(-20) : rnd(),
          (t == 6) ? ps_t'(30) : rnd(), (t == 7) ? ps_t'(-40) : rnd());
    chk("t2_valid", 64'(out_valid), 64'(1));
    chk("t2_res0", 64'(res0), 64'(ps_t'(10)));
    chk("t2_res1", 64'(res1), 64'(ps_t'(-20)));
    chk("t2_res2", 64'(res2), 64'(ps_t'(30)));
    chk("t2_res3", 64'(res3), 64'(ps_t'(-40)));
    chk("t2_idx", 64'(row_idx), 64'(0));
    cyc(1, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
    chk("t2_popped", 64'(out_valid), 64'(0));
    chk("t2_idx_next", 64'(row_idx), 64'(1));

    // back-to-back fill, then ordered drain
    for (int t = 0; t < 12; t++) begin
      cyc(1, 0, (t < 4), 0, t3v(t, 0), t3v(t, 1), t3v(t, 2), t3v(t, 3));
      if (t == 3) chk("t3_rdy_low", 64'(in_ready), 64'(0));
    end
    chk("t3_occ_full", 64'(occupancy), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", 64'(res1), 64'(ps_t'(100 * k + 1)));
      cyc(1, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
      if (k == 0) chk("t3_rdy_back", 64'(in_ready), 64'(1));
    end

    // signed extremes
    for (int t = 0; t < 8; t++)
      cyc(1, 0, (t == 0), 0, PMIN, PMAX, PMIN, PMAX);
    chk("t4_res0", 64'(res0), 64'(PMIN));
    chk("t4_res1", 64'(res1), 64'(PMAX));
    chk("t4_res2", 64'(res2), 64'(PMIN));
    chk("t4_res3", 64'(res3), 64'(PMAX));
    for (int t = 0; t < 2; t++) cyc(1, 0, 0, 1, rnd(), rnd(), rnd(), rnd());

    // weight-load gating, and no flush when L rises
    for (int t = 0; t < 5; t++) cyc(1, 1, 1, 0, rnd(), rnd(), rnd(), rnd());
    for (int t = 0; t < 8; t++) cyc(1, 0, 0, 0, rnd(), rnd(), rnd(), rnd());
    chk("t5_no_rows", 64'(occupancy), 64'(0));
    chk("t5_rdy", 64'(in_ready), 64'(1));
    cyc(1, 0, 1, 0, rnd(), rnd(), rnd(), rnd());
    for (int t = 0; t < 8; t++) cyc(1, 1, 0, 0, rnd(), rnd(), rnd(), rnd());
    chk("t5_arrived", 64'(out_valid), 64'(1));
    for (int t = 0; t < 2; t++) cyc(1, 0, 0, 1, rnd(), rnd(), rnd(), rnd());

    // reset with two rows buffered and one in flight
    cyc(1, 0, 1, 0, rnd(), rnd(), rnd(), rnd());
    cyc(1, 0, 1, 0, rnd(), rnd(), rnd(), rnd());
    for (int t = 0; t < 7; t++) cyc(1, 0, 0, 0, rnd(), rnd(), rnd(), rnd());
    chk("t6_two_buf", 64'(occupancy), 64'(2));
    cyc(1, 0, 1, 0, rnd(), rnd(), rnd(), rnd());
    cyc(0, 0, 0, 0, rnd(), rnd(), rnd(), rnd());
    for (int t = 0; t < 12; t++) begin
      cyc(1, 0, 0, 1, rnd(), rnd(), rnd(), rnd());
      chk("t6_cleared", 64'(out_valid), 64'(0));
    end

    // random traffic with alternating backpressure regimes and rare resets
    for (int i = 0; i < 2500; i++)
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 99) < (((i / 200) % 2) != 0 ? 80 : 25)),
          rnd(), rnd(), rnd(), rnd());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
